// File: rtl/pp_fifo_pkg.sv
// pp_fifo_pkg: shared helpers for the pp_pipeline_accel stream FIFOs.
//   clog2          - ceiling log2, used to size pointers and counters
//   FIFO_PTR_EMPTY - all-ones SRL pointer value meaning "SRL holds no words"
//   thresh_legal   - checks AE_THRESH < AF_THRESH <= DEPTH
package pp_fifo_pkg;

  // Wide enough for any legal depth; users slice it to their pointer width.
  localparam logic [31:0] FIFO_PTR_EMPTY = 32'hFFFF_FFFF;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit thresh_legal(input int ae, input int af, input int depth);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_fifo_srl_store.sv
// pp_pipeline_accel_fifo_srl_store: SRL-style shift register storage.
//   clk  - clock
//   ce   - shift enable; data enters at entry 0, older words move up by one
//   data - word shifted in
//   a    - read index (0 = newest); indices past the last entry read as 0
//   q    - combinational read of entry a
// No reset: contents are only meaningful where the owner's pointer says so.
module pp_pipeline_accel_fifo_srl_store
  import pp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 6,
  parameter int AW         = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  ce,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [AW-1:0]         a,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Shift register: newest word at entry 0.
  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // Read mux; the all-ones "empty" pointer falls outside the array.
  always_comb begin
    if (int'(a) < DEPTH) begin
      q = mem[a];
    end else begin
      q = '0;
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_fifo_srl_oreg.sv
// pp_pipeline_accel_fifo_srl_oreg: stream FIFO built from an SRL plus a
// registered output word, so if_dout always comes straight from a flop.
//   clk, reset               - clock, synchronous active-high reset
//   if_flush                 - discard all contents (errors kept)
//   if_err_clr               - clear sticky overflow/underflow
//   if_write/_ce, if_din     - write side; if_full_n = space available
//   if_read/_ce, if_dout     - read side; if_empty_n = if_dout valid
//   if_num_data_valid        - occupancy (output register + SRL)
//   if_fifo_cap              - constant DEPTH
//   if_almost_full/_empty    - registered threshold flags
//   if_overflow/_underflow   - sticky error flags
module pp_pipeline_accel_fifo_srl_oreg
  import pp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 7,
  parameter int ADDR_WIDTH = clog2(DEPTH),
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_flush,
  input  logic                  if_err_clr,
  input  logic                  if_write,
  input  logic                  if_write_ce,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  input  logic                  if_read_ce,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap,
  output logic                  if_almost_full,
  output logic                  if_almost_empty,
  output logic                  if_overflow,
  output logic                  if_underflow
);

  if (!thresh_legal(AE_THRESH, AF_THRESH, DEPTH)) begin : g_bad_thresh
    $error("pp_pipeline_accel_fifo_srl_oreg: need AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (ADDR_WIDTH != clog2(DEPTH) || DEPTH < 2 || DEPTH > 1024) begin : g_bad_depth
    $error("pp_pipeline_accel_fifo_srl_oreg: bad DEPTH/ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH-1:0] PTR_EMPTY = FIFO_PTR_EMPTY[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   CAP       = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_LVL    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0]   AE_LVL    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  empty_n_q, empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [DATA_WIDTH-1:0] oreg_q, oreg_d;

  logic                  wr, rd, wa, ra, srl_empty, srl_ce;
  logic [DATA_WIDTH-1:0] srl_q;

  assign wr        = if_write & if_write_ce;
  assign rd        = if_read & if_read_ce;
  assign wa        = wr & full_n_q;
  assign ra        = rd & empty_n_q;
  assign srl_empty = (ptr_q == PTR_EMPTY);

  pp_pipeline_accel_fifo_srl_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH - 1)
  ) u_store (
    .clk (clk),
    .ce  (srl_ce),
    .data(if_din),
    .a   (ptr_q),
    .q   (srl_q)
  );

  // Next-state for occupancy, SRL pointer and output register.
  always_comb begin
    ptr_d     = ptr_q;
    count_d   = count_q;
    empty_n_d = empty_n_q;
    oreg_d    = oreg_q;
    srl_ce    = 1'b0;
    if (if_flush) begin
      count_d   = '0;
      ptr_d     = PTR_EMPTY;
      empty_n_d = 1'b0;
    end else begin
      count_d = count_q + (ADDR_WIDTH+1)'(wa) - (ADDR_WIDTH+1)'(ra);
      case ({wa, ra})
        2'b10: begin
          if (!empty_n_q) begin
            oreg_d    = if_din;      // bypass the SRL when nothing is held
            empty_n_d = 1'b1;
          end else begin
            srl_ce = 1'b1;
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
          end
        end
        2'b01: begin
          if (!srl_empty) begin
            oreg_d = srl_q;
            ptr_d  = ptr_q - ADDR_WIDTH'(1);
          end else begin
            empty_n_d = 1'b0;        // oreg keeps its stale word
          end
        end
        2'b11: begin
          if (!srl_empty) begin
            // srl_q is sampled before the shift, so the pointer stays put.
            oreg_d = srl_q;
            srl_ce = 1'b1;
          end else begin
            oreg_d = if_din;
          end
        end
        default: begin
          ptr_d = ptr_q;
        end
      endcase
    end
    full_n_d = (count_d != CAP);
    af_d     = (count_d >= AF_LVL);
    ae_d     = (count_d <= AE_LVL);
  end

  // Sticky errors: a set event wins over a coincident clear.
  always_comb begin
    ovf_d = (wr & ~full_n_q) | (ovf_q & ~if_err_clr);
    unf_d = (rd & ~empty_n_q) | (unf_q & ~if_err_clr);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      ptr_q     <= PTR_EMPTY;
      empty_n_q <= 1'b0;
      full_n_q  <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      oreg_q    <= '0;
    end else begin
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      empty_n_q <= empty_n_d;
      full_n_q  <= full_n_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      oreg_q    <= oreg_d;
    end
  end

  assign if_dout           = oreg_q;
  assign if_empty_n        = empty_n_q;
  assign if_full_n         = full_n_q;
  assign if_num_data_valid = count_q;
  assign if_fifo_cap       = CAP;
  assign if_almost_full    = af_q;
  assign if_almost_empty   = ae_q;
  assign if_overflow       = ovf_q;
  assign if_underflow      = unf_q;

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_srl_oreg.sv
module tb_pp_pipeline_accel_fifo_srl_oreg;

  localparam int DW    = 32;
  localparam int DEPTH = 7;
  localparam int AW    = 3;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_flush, if_err_clr;
  logic          if_write, if_write_ce, if_read, if_read_ce;
  logic [DW-1:0] if_din, if_dout;
  logic          if_full_n, if_empty_n, if_almost_full, if_almost_empty;
  logic          if_overflow, if_underflow;
  logic [AW:0]   if_num_data_valid, if_fifo_cap;

  int total = 0;
  int bad   = 0;

  // Reference model: a plain queue of words plus two sticky bits.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;

  pp_pipeline_accel_fifo_srl_oreg #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset), .if_flush(if_flush), .if_err_clr(if_err_clr),
    .if_write(if_write), .if_write_ce(if_write_ce), .if_din(if_din),
    .if_full_n(if_full_n), .if_read(if_read), .if_read_ce(if_read_ce),
    .if_dout(if_dout), .if_empty_n(if_empty_n),
    .if_num_data_valid(if_num_data_valid), .if_fifo_cap(if_fifo_cap),
    .if_almost_full(if_almost_full), .if_almost_empty(if_almost_empty),
    .if_overflow(if_overflow), .if_underflow(if_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit wr, input bit rd, input logic [DW-1:0] d,
                              input bit fl, input bit clr);
    bit full, empty, os, us;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    os    = wr && full;
    us    = rd && empty;
    if (fl) begin
      mq.delete();
    end else begin
      if (rd && !empty) void'(mq.pop_front());
      if (wr && !full) mq.push_back(d);
    end
    m_ovf = os || (m_ovf && !clr);
    m_unf = us || (m_unf && !clr);
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"},   DW'(if_num_data_valid), DW'(n));
    chk({tag, ":full_n"},  DW'(if_full_n),        DW'(n != DEPTH));
    chk({tag, ":empty_n"}, DW'(if_empty_n),       DW'(n != 0));
    chk({tag, ":af"},      DW'(if_almost_full),   DW'(n >= AF));
    chk({tag, ":ae"},      DW'(if_almost_empty),  DW'(n <= AE));
    chk({tag, ":ovf"},     DW'(if_overflow),      DW'(m_ovf));
    chk({tag, ":unf"},     DW'(if_underflow),     DW'(m_unf));
    if (n > 0) chk({tag, ":dout"}, if_dout, mq[0]);
  endtask

  task automatic idle();
    if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
    if_flush = 1'b0; if_err_clr = 1'b0; if_din = '0;
  endtask

  // One clock: drive, clock, update model, settle, then return inputs to idle.
  task automatic step(input bit w, input bit wce, input logic [DW-1:0] d,
                      input bit r, input bit rce, input bit fl, input bit clr);
    if_write = w; if_write_ce = wce; if_din = d;
    if_read = r; if_read_ce = rce; if_flush = fl; if_err_clr = clr;
    @(posedge clk);
    model_update(w && wce, r && rce, d, fl, clr);
    #1;
    idle();
  endtask

  task automatic wr1(input logic [DW-1:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    check_all("reset");
    chk("reset:dout", if_dout, 32'h0);
    chk("reset:cap", DW'(if_fifo_cap), 32'd7);
    reset = 1'b0;

    // Single write goes straight to the output register.
    wr1(32'hA0);
    check_all("wA0");
    chk("wA0:dout", if_dout, 32'hA0);
    chk("wA0:ae", DW'(if_almost_empty), 32'd1);
    rd1();
    check_all("rA0");

    // Fill to capacity, overflow, then drain in order.
    for (int i = 1; i <= DEPTH; i++) begin
      wr1(DW'(i));
      check_all($sformatf("fill%0d", i));
    end
    chk("fill:full_n", DW'(if_full_n), 32'd0);
    wr1(32'h08);
    check_all("ovf");
    chk("ovf:flag", DW'(if_overflow), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("drain%0d:head", i), if_dout, DW'(i));
      rd1();
      check_all($sformatf("drain%0d", i));
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("clr_ovf");

    // Simultaneous read/write at count 3.
    wr1(32'h11); wr1(32'h22); wr1(32'h33);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0);
      check_all($sformatf("rw3_%0d", i));
      chk("rw3:count", DW'(if_num_data_valid), 32'd3);
    end
    for (int i = 0; i < 2; i++) begin
      rd1();
      check_all("rw3_drain");
    end

    // Count 1, read+write replaces the head.
    step(1'b1, 1'b1, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("rw1");
    chk("rw1:dout", if_dout, 32'h77);
    chk("rw1:empty_n", DW'(if_empty_n), 32'd1);

    // Flush with a write at count 4.
    wr1(32'h91); wr1(32'h92); wr1(32'h93);
    check_all("pre_flush");
    step(1'b1, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("flush");
    chk("flush:count", DW'(if_num_data_valid), 32'd0);
    chk("flush:full_n", DW'(if_full_n), 32'd1);
    chk("flush:ovf", DW'(if_overflow), 32'd0);

    // Underflow and clear behaviour.
    rd1();
    check_all("unf");
    chk("unf:flag", DW'(if_underflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("unf_clr");
    chk("unf_clr:flag", DW'(if_underflow), 32'd0);
    rd1();
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_all("unf_set_wins");
    chk("unf_set_wins:flag", DW'(if_underflow), 32'd1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 9) != 0), DW'($urandom()),
           1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 9) != 0),
           1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 29) == 0));
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
